bus_arbiter: RTL and testbench

Two-to-one memory bus arbiter placed between the pipelined core and the single external memory port. It accepts the instruction-fetch request (ibus) and the load/store request (dbus) and grants one of them at a time. It registers the granted request onto the shared port and routes the response back to the owner as a one-cycle `data_ok` pulse. Each transaction is single-beat, and exactly one transaction is outstanding at a time.

---
 rtl/bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-to-one arbiter between the instruction-fetch bus (ibus)
// and the load/store bus (dbus) in front of a single memory port. One
// single-beat transaction is outstanding at a time. The granted request is
// registered onto the shared port, and the response returns to the owner as
// a combinational one-cycle data_ok pulse.
// Optional feature macro: BUS_ARBITER_RR_EN selects round-robin tie breaking.
// When it is undefined, dbus always wins ties.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction-fetch side
  input  logic                  ireq_valid,
  input  logic [ADDR_W-1:0]     ireq_addr,
  output logic                  iresp_data_ok,
  output logic [31:0]           iresp_data,
  // load/store side
  input  logic                  dreq_valid,
  input  logic [ADDR_W-1:0]     dreq_addr,
  input  logic [2:0]            dreq_size,
  input  logic [DATA_W/8-1:0]   dreq_strobe,
  input  logic [DATA_W-1:0]     dreq_data,
  output logic                  dresp_data_ok,
  output logic [DATA_W-1:0]     dresp_data,
  // shared memory port
  output logic                  oreq_valid,
  output logic                  oreq_is_write,
  output logic [ADDR_W-1:0]     oreq_addr,
  output logic [2:0]            oreq_size,
  output logic [DATA_W/8-1:0]   oreq_strobe,
  output logic [DATA_W-1:0]     oreq_data,
  input  logic                  oresp_ready,
  input  logic                  oresp_last,
  input  logic [DATA_W-1:0]     oresp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] FETCH_SIZE = 3'b010;  // fetches are always 32-bit

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                w_grant_i;
  logic                w_grant_d;

  logic                r_oreq_valid;
  logic                r_oreq_is_write;
  logic [ADDR_W-1:0]   r_oreq_addr;
  logic [2:0]          r_oreq_size;
  logic [STRB_W-1:0]   r_oreq_strobe;
  logic [DATA_W-1:0]   r_oreq_data;

`ifdef BUS_ARBITER_RR_EN
  // 1 means dbus won the most recent grant; resets to "instruction won" so
  // the first tie after reset goes to dbus.
  logic r_last_d;

  // Tie breaking: on a tie the side that lost last time wins; a lone requester always wins
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (dreq_valid && ireq_valid) begin
      w_grant_d = !r_last_d;
      w_grant_i = r_last_d;
    end else begin
      w_grant_d = dreq_valid;
      w_grant_i = ireq_valid;
    end
  end

  // Record the winner of every grant taken from IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: dbus wins every tie
  always_comb begin
    w_grant_d = dreq_valid;
    w_grant_i = ireq_valid && !dreq_valid;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and owner completion pulses. A pulse needs the owner to
  // still hold its valid; an abandoned request completes silently. A beat
  // without last is a protocol error and sends us to DRAIN until a proper end.
  always_comb begin
    w_state_next  = r_state;
    iresp_data_ok = 1'b0;
    dresp_data_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_next = BUSY_D;
        end else if (w_grant_i) begin
          w_state_next = BUSY_I;
        end
      end
      BUSY_I: begin
        if (oresp_ready) begin
          if (oresp_last) begin
            iresp_data_ok = ireq_valid;
            w_state_next  = IDLE;
          end else begin
            w_state_next  = DRAIN;
          end
        end
      end
      BUSY_D: begin
        if (oresp_ready) begin
          if (oresp_last) begin
            dresp_data_ok = dreq_valid;
            w_state_next  = IDLE;
          end else begin
            w_state_next  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (oresp_ready && oresp_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Shared-port request registers: loaded on the grant edge, frozen while busy,
  // valid dropped on the completion edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oreq_valid    <= 1'b0;
      r_oreq_is_write <= 1'b0;
      r_oreq_addr     <= '0;
      r_oreq_size     <= '0;
      r_oreq_strobe   <= '0;
      r_oreq_data     <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        r_oreq_valid    <= 1'b1;
        r_oreq_is_write <= |dreq_strobe;
        r_oreq_addr     <= dreq_addr;
        r_oreq_size     <= dreq_size;
        r_oreq_strobe   <= dreq_strobe;
        r_oreq_data     <= dreq_data;
      end else if (w_grant_i) begin
        r_oreq_valid    <= 1'b1;
        r_oreq_is_write <= 1'b0;
        r_oreq_addr     <= ireq_addr;
        r_oreq_size     <= FETCH_SIZE;
        r_oreq_strobe   <= '0;
        r_oreq_data     <= '0;
      end
    end else if (w_state_next == IDLE) begin
      r_oreq_valid <= 1'b0;
    end
  end

  assign oreq_valid    = r_oreq_valid;
  assign oreq_is_write = r_oreq_is_write;
  assign oreq_addr     = r_oreq_addr;
  assign oreq_size     = r_oreq_size;
  assign oreq_strobe   = r_oreq_strobe;
  assign oreq_data     = r_oreq_data;

  // Response data is steered straight from the port; the fetch side picks
  // the 32-bit half addressed by bit 2 of its address.
  assign iresp_data = ireq_addr[2] ? oresp_data[32 +: 32] : oresp_data[0 +: 32];
  assign dresp_data = oresp_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed stimulus, expected responses
// queued when a transaction is issued and compared when a data_ok pulse appears.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        oreq_valid;
  logic        oreq_is_write;
  logic [63:0] oreq_addr;
  logic [2:0]  oreq_size;
  logic [7:0]  oreq_strobe;
  logic [63:0] oreq_data;
  logic        oresp_ready;
  logic        oresp_last;
  logic [63:0] oresp_data;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_addr(oreq_addr),
    .oreq_size(oreq_size), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_d, input logic [63:0] d);
    mk_exp = {is_d, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every data_ok pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (iresp_data_ok || dresp_data_ok) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ok", {62'd0, iresp_data_ok, dresp_data_ok}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ok_owner", {62'd0, iresp_data_ok, dresp_data_ok}, mon_e.is_d ? 64'd1 : 64'd2);
        check_eq("resp_data", mon_e.is_d ? dresp_data : {32'd0, iresp_data}, mon_e.data);
        $display("txn %s data=%h", mon_e.is_d ? "D" : "I", mon_e.is_d ? dresp_data : {32'd0, iresp_data});
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  logic [2:0]  order;
  logic [63:0] rdata;
  logic        exp_d;

  initial begin
`ifdef BUS_ARBITER_RR_EN
    order = 3'b101;  // D, I, D
`else
    order = 3'b111;  // D, D, D
`endif
    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    oresp_ready = 1'b0; oresp_last = 1'b0; oresp_data = '0;
    repeat (3) tick();

    // reset state
    check_eq("rst_valid",  64'(oreq_valid), 64'd0);
    check_eq("rst_addr",   oreq_addr, 64'd0);
    check_eq("rst_data",   oreq_data, 64'd0);
    check_eq("rst_strobe", 64'(oreq_strobe), 64'd0);
    check_eq("rst_size",   64'(oreq_size), 64'd0);
    reset = 1'b0;
    tick();

    // single fetch, response in first busy cycle
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    check_eq("t1_pre_grant", 64'(oreq_valid), 64'd0);
    tick();
    check_eq("t1_valid",  64'(oreq_valid), 64'd1);
    check_eq("t1_size",   64'(oreq_size), 64'd2);
    check_eq("t1_strobe", 64'(oreq_strobe), 64'd0);
    check_eq("t1_iswr",   64'(oreq_is_write), 64'd0);
    check_eq("t1_addr",   oreq_addr, 64'h8000_0004);
    exp_q.push_back(mk_exp(1'b0, 64'h0000_0000_DEAD_BEEF));
    oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = 64'hDEAD_BEEF_0000_0013;
    tick();
    oresp_ready = 1'b0; ireq_valid = 1'b0;
    check_eq("t1_pulse_seen", 64'(exp_q.size()), 64'd0);
    check_eq("t1_valid_clr",  64'(oreq_valid), 64'd0);
    tick();

    // store, inputs changed while busy must not disturb the registers
    dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_strobe = 8'h0F;
    dreq_data = 64'h1122_3344_5566_7788; dreq_size = 3'b011;
    tick();
    check_eq("t2_iswr",   64'(oreq_is_write), 64'd1);
    check_eq("t2_addr",   oreq_addr, 64'h8000_1000);
    check_eq("t2_strobe", 64'(oreq_strobe), 64'h0F);
    check_eq("t2_data",   oreq_data, 64'h1122_3344_5566_7788);
    check_eq("t2_size",   64'(oreq_size), 64'd3);
    dreq_data = 64'hFFFF_0000_FFFF_0000; dreq_addr = 64'h1234;
    tick();
    check_eq("t2_frozen_data", oreq_data, 64'h1122_3344_5566_7788);
    check_eq("t2_frozen_addr", oreq_addr, 64'h8000_1000);
    exp_q.push_back(mk_exp(1'b1, 64'h0123_4567_89AB_CDEF));
    oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = 64'h0123_4567_89AB_CDEF;
    tick();
    oresp_ready = 1'b0; dreq_valid = 1'b0;
    check_eq("t2_pulse_seen", 64'(exp_q.size()), 64'd0);
    check_eq("t2_valid_clr",  64'(oreq_valid), 64'd0);

    // ties from a fresh reset: three transactions with both sides requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ireq_addr = 64'h8000_0010; dreq_addr = 64'h8000_2000; dreq_strobe = 8'h00;
    dreq_size = 3'b011; ireq_valid = 1'b1; dreq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_d = order[k];
      check_eq($sformatf("t3_grant%0d_addr", k), oreq_addr, exp_d ? 64'h8000_2000 : 64'h8000_0010);
      rdata = {32'hA5A5_0000 | 32'(k), 32'h1234_0000 | 32'(k)};
      exp_q.push_back(mk_exp(exp_d, exp_d ? rdata : {32'd0, rdata[31:0]}));
      oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = rdata;
      tick();
      oresp_ready = 1'b0;
      check_eq($sformatf("t3_pulse%0d_seen", k), 64'(exp_q.size()), 64'd0);
      check_eq($sformatf("t3_gap%0d", k), 64'(oreq_valid), 64'd0);
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    tick();

    // abandoned fetch: valid dropped and address changed before the response
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0020;
    tick();
    check_eq("t4_addr", oreq_addr, 64'h8000_0020);
    ireq_valid = 1'b0; ireq_addr = 64'h9000_0000;
    tick();
    check_eq("t4_addr_frozen", oreq_addr, 64'h8000_0020);
    check_eq("t4_still_busy",  64'(oreq_valid), 64'd1);
    oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = 64'h5555_6666_7777_8888;
    #1;
    check_eq("t4_no_ok", 64'(iresp_data_ok), 64'd0);
    tick();
    oresp_ready = 1'b0;
    check_eq("t4_idle", 64'(oreq_valid), 64'd0);
    tick();

    // reset in BUSY_D, response arrives five cycles after the grant
    dreq_valid = 1'b1; dreq_addr = 64'h8000_3000; dreq_strobe = 8'hFF;
    dreq_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    check_eq("t5_valid", 64'(oreq_valid), 64'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("t5_rst_valid", 64'(oreq_valid), 64'd0);
    check_eq("t5_rst_addr",  oreq_addr, 64'd0);
    check_eq("t5_rst_data",  oreq_data, 64'd0);
    check_eq("t5_rst_iswr",  64'(oreq_is_write), 64'd0);
    dreq_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = 64'h1111_2222_3333_4444;
    #1;
    check_eq("t5_late_no_ok", 64'(dresp_data_ok), 64'd0);
    tick();
    oresp_ready = 1'b0;
    check_eq("t5_idle", 64'(oreq_valid), 64'd0);

    // ready without last: DRAIN, no pulse, then IDLE
    dreq_valid = 1'b1; dreq_addr = 64'h8000_4000; dreq_strobe = 8'h00;
    tick();
    check_eq("t6_iswr", 64'(oreq_is_write), 64'd0);
    oresp_ready = 1'b1; oresp_last = 1'b0; oresp_data = 64'h7777_7777_7777_7777;
    #1;
    check_eq("t6_no_ok_nolast", 64'(dresp_data_ok), 64'd0);
    tick();
    oresp_ready = 1'b0;
    check_eq("t6_drain_valid", 64'(oreq_valid), 64'd1);
    tick();
    check_eq("t6_drain_valid2", 64'(oreq_valid), 64'd1);
    oresp_ready = 1'b1; oresp_last = 1'b1;
    #1;
    check_eq("t6_drain_no_ok", 64'(dresp_data_ok), 64'd0);
    tick();
    oresp_ready = 1'b0; dreq_valid = 1'b0;
    check_eq("t6_idle", 64'(oreq_valid), 64'd0);
    tick();

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
